texel_dispatcher: RTL and testbench
===================================

Name: texel_dispatcher

Overview:
- Sequences the texel assembler: pulls each completed triangle/colour record and dispatches it to one of NUM_LANES downstream rasterizer lanes.
- Lanes are chosen round-robin.
- Sits between the texel assembler outputs (texel_ready, texel_vertices_out, texel_color_out, texel_read) and the rasterizer lane inputs.
- Holds one record, so the assembler can start collecting the next frame while arbitration proceeds.

Parameters:
- NUM_LANES, 4, number of rasterizer lanes; legal range 2..8.
- COUNT_WIDTH, 16, width of the dispatched-record counter.
- TIMEOUT_CYCLES, 256, ARB stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = accept new records; 0 = finish any in-flight record, then accept nothing.
- texel_ready  in  1  assembler holds a complete record.
- texel_vertices_in  in  Triangle3D (144)  assembler vertex output.
- texel_color_in  in  Color (24)  assembler colour output.
- texel_read  out  1  one-cycle pulse; acknowledges the record to the assembler.
- lane_busy  in  NUM_LANES  bit i = 1 when lane i cannot accept a record.
- lane_start  out  NUM_LANES  one-hot, one-cycle pulse naming the target lane.
- lane_vertices_out  out  Triangle3D  shared bus; valid whenever lane_start != 0.
- lane_color_out  out  Color  shared bus; valid whenever lane_start != 0.
- dispatch_count  out  COUNT_WIDTH  number of records issued since reset.
- idle  out  1  1 when in IDLE with no record held.
- stall_error  out  1  sticky; see Optional Feature.

Behaviour:
- Reset values: every output is 0 except idle = 1. Hold registers = 0, rr_ptr = 0, state = IDLE.
- Reset asserted mid-operation discards the held record. No lane_start is issued for it, and no second texel_read is issued for it.
- States: IDLE, ARB, ISSUE.
- IDLE: at the edge where enable = 1 and texel_ready = 1:
  - capture texel_vertices_in/texel_color_in into hold registers;
  - set texel_read = 1 for exactly the next cycle;
  - go to ARB.
  - Otherwise stay in IDLE.
- ARB:
  - Search lanes rr_ptr, rr_ptr+1, … (mod NUM_LANES) for the first lane with lane_busy = 0.
  - If lane k is found, at the edge: lane_start = onehot(k), rr_ptr = (k+1) mod NUM_LANES, dispatch_count += 1, go to ISSUE.
  - If all lanes are busy, stay in ARB. Hold registers remain stable. lane_start remains 0.
- ISSUE:
  - lane_start is high for this cycle only.
  - lane_*_out show the hold registers.
  - Next state is IDLE; lane_start returns to 0.
- Timing:
  - Minimum IDLE-to-IDLE cycle is 3 clocks, which guarantees the assembler has dropped texel_ready before the next IDLE sample.
  - Record-capture to lane_start latency is 1 clock plus the arbitration wait.
- lane_vertices_out/lane_color_out are driven directly from the hold registers. They are undefined for lanes when lane_start = 0.
- enable is sampled only in IDLE. Deasserting enable in ARB/ISSUE does not abort the record.
- texel_ready high while in ARB/ISSUE is ignored. It is re-sampled on return to IDLE.
- lane_busy is sampled only in ARB. A lane freeing in the same cycle another lane becomes busy is resolved by the values sampled at that edge.
- dispatch_count wraps from 2^COUNT_WIDTH−1 to 0 with no flag.
- idle = (state == IDLE), registered.

Optional Feature:
- Macro: DISPATCH_TIMEOUT_EN.
- With the macro defined:
  - A stall counter clears on entry to ARB and increments each cycle spent in ARB.
  - When it reaches TIMEOUT_CYCLES, stall_error is set. It stays set until reset.
  - Dispatching continues normally afterwards.
- Without the macro: the stall_error port exists and is tied to 0, and no counter logic is present.

Test Plan:
- Reset check: hold n_rst = 0 for 2 clocks → lane_start = 0, texel_read = 0, dispatch_count = 0, idle = 1, stall_error = 0.
- Single dispatch:
  - Stimulus: enable = 1, lane_busy = 4'b0000, texel_ready rises with vertices p.x = 16'h1100, colour r = 8'h99.
  - Response: texel_read pulses 1 clock later; lane_start = 4'b0001 on the following edge; lane_vertices_out.p.x = 16'h1100; dispatch_count = 1.
- Round-robin:
  - Stimulus: 5 back-to-back records, all lanes free.
  - Response: lane_start sequence 0001, 0010, 0100, 1000, 0001; dispatch_count = 5.
- Busy skip and stall:
  - Stimulus: lane_busy = 4'b1111 for 10 clocks, then 4'b1011.
  - Response: no lane_start while all lanes are busy; texel_read pulses only once; then lane_start = 4'b0100 with unchanged data.
- Enable and reset mid-flight:
  - Stimulus: enable drops during ARB.
  - Response: the current record still issues, then the block stays idle with texel_ready = 1.
  - Stimulus: assert n_rst low during ARB.
  - Response: no lane_start, idle = 1 after release.
- Timeout (DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES = 8):
  - Stimulus: all lanes busy for 8 clocks in ARB.
  - Response: stall_error = 1 and it stays 1 after the subsequent successful dispatch.
  - Without the macro, stall_error stays 0.

Source files
------------

// File: rtl/texel_dispatcher.sv
// texel_dispatcher: holds one assembler record and issues it round-robin to NUM_LANES rasterizer lanes.
// Define DISPATCH_TIMEOUT_EN to enable the sticky stall_error after TIMEOUT_CYCLES spent in arbitration.

module texel_dispatcher #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   enable,
  input  logic                   texel_ready,
  input  logic [143:0]           texel_vertices_in,
  input  logic [23:0]            texel_color_in,
  output logic                   texel_read,
  input  logic [NUM_LANES-1:0]   lane_busy,
  output logic [NUM_LANES-1:0]   lane_start,
  output logic [143:0]           lane_vertices_out,
  output logic [23:0]            lane_color_out,
  output logic [COUNT_WIDTH-1:0] dispatch_count,
  output logic                   idle,
  output logic                   stall_error
);

  localparam int unsigned PTR_W = $clog2(NUM_LANES);

  // Reject configurations the round-robin pointer and stall counter cannot represent.
  if (NUM_LANES < 2 || NUM_LANES > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("texel_dispatcher: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]       pick_c;
  logic                   found_c;
  logic [NUM_LANES-1:0]   onehot_c;
  logic [NUM_LANES-1:0]   lane_start_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   texel_read_d;
  logic                   cap_c;
  int unsigned            idx;

  // First free lane at or after rr_q, wrapping modulo NUM_LANES.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      idx = (32'(rr_q) + i) % NUM_LANES;
      if (!found_c && !lane_busy[PTR_W'(idx)]) begin
        found_c = 1'b1;
        pick_c  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      onehot_c[i] = (32'(pick_c) == i);
    end
  end

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    count_d      = dispatch_count;
    lane_start_d = '0;
    texel_read_d = 1'b0;
    cap_c        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && texel_ready) begin
          cap_c        = 1'b1;
          texel_read_d = 1'b1;
          state_d      = S_ARB;
        end
      end
      S_ARB: begin
        if (found_c) begin
          lane_start_d = onehot_c;
          rr_d         = (pick_c == PTR_W'(NUM_LANES - 1)) ? '0 : pick_c + 1'b1;
          count_d      = dispatch_count + 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The lane data buses are the hold registers themselves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q           <= S_IDLE;
      rr_q              <= '0;
      texel_read        <= 1'b0;
      lane_start        <= '0;
      dispatch_count    <= '0;
      idle              <= 1'b1;
      lane_vertices_out <= '0;
      lane_color_out    <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      texel_read     <= texel_read_d;
      lane_start     <= lane_start_d;
      dispatch_count <= count_d;
      idle           <= (state_d == S_IDLE);
      if (cap_c) begin
        lane_vertices_out <= texel_vertices_in;
        lane_color_out    <= texel_color_in;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;

  // Counter is held at zero outside arbitration, so it starts from zero on every ARB entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_q     <= '0;
      stall_error <= 1'b0;
    end else if (state_q == S_ARB) begin
      if (stall_q != STALL_W'(TIMEOUT_CYCLES)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
        stall_error <= 1'b1;
      end
    end else begin
      stall_q <= '0;
    end
  end
`else
  assign stall_error = 1'b0;
`endif

endmodule

// File: tb/tb_texel_dispatcher.sv
// Directed self-checking bench for texel_dispatcher (4 lanes, TIMEOUT_CYCLES = 8).
// Inputs change and outputs are sampled on the falling edge of tb_clk.

module tb_texel_dispatcher;

  localparam int unsigned NL = 4;
  localparam int unsigned CW = 16;

`ifdef DISPATCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic          enable;
  logic          texel_ready;
  logic [143:0]  texel_vertices_in;
  logic [23:0]   texel_color_in;
  logic          texel_read;
  logic [NL-1:0] lane_busy;
  logic [NL-1:0] lane_start;
  logic [143:0]  lane_vertices_out;
  logic [23:0]   lane_color_out;
  logic [CW-1:0] dispatch_count;
  logic          idle;
  logic          stall_error;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  texel_dispatcher #(
    .NUM_LANES      (NL),
    .COUNT_WIDTH    (CW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (tb_clk),
    .n_rst             (n_rst),
    .enable            (enable),
    .texel_ready       (texel_ready),
    .texel_vertices_in (texel_vertices_in),
    .texel_color_in    (texel_color_in),
    .texel_read        (texel_read),
    .lane_busy         (lane_busy),
    .lane_start        (lane_start),
    .lane_vertices_out (lane_vertices_out),
    .lane_color_out    (lane_color_out),
    .dispatch_count    (dispatch_count),
    .idle              (idle),
    .stall_error       (stall_error)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    n_rst       = 1'b0;
    texel_ready = 1'b0;
    repeat (2) @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
  endtask

  // One record with every lane free; returns on the negedge after the block is back in IDLE.
  task automatic run_free(input string tag, input logic [143:0] v, input logic [23:0] c,
                          input logic [NL-1:0] exp_lane, input logic [CW-1:0] exp_cnt);
    texel_vertices_in = v;
    texel_color_in    = c;
    texel_ready       = 1'b1;
    @(negedge tb_clk);
    chk({tag, ".read"}, 160'(texel_read), 160'(1'b1));
    texel_ready       = 1'b0;
    texel_vertices_in = '0;
    @(negedge tb_clk);
    chk({tag, ".lane"},  160'(lane_start), 160'(exp_lane));
    chk({tag, ".vert"},  160'(lane_vertices_out), 160'(v));
    chk({tag, ".color"}, 160'(lane_color_out), 160'(c));
    chk({tag, ".count"}, 160'(dispatch_count), 160'(exp_cnt));
    @(negedge tb_clk);
    chk({tag, ".idle"}, 160'(idle), 160'(1'b1));
  endtask

  logic [143:0] v1;
  logic [143:0] vr;
  logic [NL-1:0] rr_exp [5];
  int unsigned   reads;

  initial begin
    n_rst             = 1'b0;
    enable            = 1'b0;
    texel_ready       = 1'b0;
    texel_vertices_in = '0;
    texel_color_in    = '0;
    lane_busy         = '0;

    // Reset values
    repeat (2) @(negedge tb_clk);
    chk("rst.lane_start", 160'(lane_start), 160'(0));
    chk("rst.texel_read", 160'(texel_read), 160'(0));
    chk("rst.count",      160'(dispatch_count), 160'(0));
    chk("rst.idle",       160'(idle), 160'(1));
    chk("rst.stall",      160'(stall_error), 160'(0));
    n_rst = 1'b1;
    @(negedge tb_clk);
    chk("rst.idle_after", 160'(idle), 160'(1));

    // Single dispatch, explicit step by step
    enable            = 1'b1;
    v1                = {16'h1100, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677};
    texel_vertices_in = v1;
    texel_color_in    = 24'h99_5a3c;
    texel_ready       = 1'b1;
    @(negedge tb_clk);
    chk("single.read",     160'(texel_read), 160'(1));
    chk("single.no_start", 160'(lane_start), 160'(0));
    chk("single.busy",     160'(idle), 160'(0));
    texel_ready       = 1'b0;
    texel_vertices_in = '0;
    @(negedge tb_clk);
    chk("single.read_once", 160'(texel_read), 160'(0));
    chk("single.lane",      160'(lane_start), 160'(4'b0001));
    chk("single.px",        160'(lane_vertices_out[143:128]), 160'(16'h1100));
    chk("single.vert",      160'(lane_vertices_out), 160'(v1));
    chk("single.r",         160'(lane_color_out[23:16]), 160'(8'h99));
    chk("single.count",     160'(dispatch_count), 160'(1));
    @(negedge tb_clk);
    chk("single.start_drop", 160'(lane_start), 160'(0));
    chk("single.idle",       160'(idle), 160'(1));

    // Round-robin over five back-to-back records from a fresh pointer
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      vr = {16'(16'h2000 + i), 128'(i * 7 + 3)};
      run_free($sformatf("rr%0d", i), vr, 24'(24'h00_1000 + i), rr_exp[i], 16'(i + 1));
    end
    chk("rr.count", 160'(dispatch_count), 160'(5));

    // All lanes busy for 10 ARB clocks, then only lane 2 free (pointer sits at lane 1)
    lane_busy         = 4'b1111;
    vr                = {16'h3300, 128'hdead_beef_0000_1111_2222_3333_4444_5555};
    texel_vertices_in = vr;
    texel_color_in    = 24'h44_5566;
    texel_ready       = 1'b1;
    @(negedge tb_clk);
    chk("stall.read",  160'(texel_read), 160'(1));
    chk("stall.err0",  160'(stall_error), 160'(0));
    texel_vertices_in = 144'h5;
    reads = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge tb_clk);
      if (texel_read) reads++;
      chk($sformatf("stall.no_start%0d", i), 160'(lane_start), 160'(0));
      chk($sformatf("stall.err%0d", i), 160'(stall_error), 160'(TO_EN && (i >= 8)));
    end
    chk("stall.read_once", 160'(reads), 160'(0));
    lane_busy   = 4'b1011;
    texel_ready = 1'b0;
    @(negedge tb_clk);
    chk("stall.lane",   160'(lane_start), 160'(4'b0100));
    chk("stall.vert",   160'(lane_vertices_out), 160'(vr));
    chk("stall.color",  160'(lane_color_out), 160'(24'h44_5566));
    chk("stall.count",  160'(dispatch_count), 160'(6));
    chk("stall.sticky", 160'(stall_error), 160'(TO_EN));
    lane_busy = 4'b0000;
    @(negedge tb_clk);
    chk("stall.idle", 160'(idle), 160'(1));

    // Enable drops during ARB: record still issues (pointer at lane 3), then no new capture
    lane_busy         = 4'b1111;
    texel_vertices_in = {16'h4400, 128'h1};
    texel_color_in    = 24'h77_0000;
    texel_ready       = 1'b1;
    @(negedge tb_clk);
    chk("en.read", 160'(texel_read), 160'(1));
    enable = 1'b0;
    @(negedge tb_clk);
    chk("en.wait", 160'(lane_start), 160'(0));
    lane_busy = 4'b0000;
    @(negedge tb_clk);
    chk("en.lane",  160'(lane_start), 160'(4'b1000));
    chk("en.vert",  160'(lane_vertices_out), 160'({16'h4400, 128'h1}));
    chk("en.count", 160'(dispatch_count), 160'(7));
    reads = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge tb_clk);
      if (texel_read) reads++;
    end
    chk("en.stay_idle",  160'(idle), 160'(1));
    chk("en.no_read",    160'(reads), 160'(0));
    chk("en.no_start",   160'(lane_start), 160'(0));
    chk("en.count_hold", 160'(dispatch_count), 160'(7));
    chk("en.sticky",     160'(stall_error), 160'(TO_EN));

    // Reset during ARB discards the held record
    enable    = 1'b1;
    lane_busy = 4'b1111;
    texel_vertices_in = {16'h5500, 128'h2};
    @(negedge tb_clk);
    chk("mrst.read", 160'(texel_read), 160'(1));
    texel_ready = 1'b0;
    @(negedge tb_clk);
    chk("mrst.in_arb", 160'(idle), 160'(0));
    n_rst = 1'b0;
    #1;
    chk("mrst.idle",  160'(idle), 160'(1));
    chk("mrst.read0", 160'(texel_read), 160'(0));
    chk("mrst.count", 160'(dispatch_count), 160'(0));
    chk("mrst.stall", 160'(stall_error), 160'(0));
    @(negedge tb_clk);
    lane_busy = 4'b0000;
    n_rst     = 1'b1;
    reads     = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge tb_clk);
      if (texel_read) reads++;
      chk($sformatf("mrst.no_start%0d", i), 160'(lane_start), 160'(0));
    end
    chk("mrst.idle_after", 160'(idle), 160'(1));
    chk("mrst.no_read",    160'(reads), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
